up_down_direction_decoder: RTL and testbench
============================================

# up_down_direction_decoder

Receive-side companion to the 2-bit up/down counter FSM. It watches the stream of 2-bit count values and recovers the direction bit that drove each step: 1 = up, 0 = down. It also flags illegal steps (hold or skip-by-2), counts them, and tracks lock to the sequence. It sits on the monitor/link side, wherever counter outputs are sampled and the original direction stream has to be reconstructed.

## Interface
- ERR_CNT_WIDTH, default 8: width of the saturating illegal-step counter.
- FAULT_LIMIT, default 3: number of consecutive illegal steps that forces loss of lock. Legal range 1..15.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low.
- Clear  input  1  synchronous clear; returns the block to the post-reset state.
- Count_In  input  2  sampled counter value.
- Count_Valid  input  1  Count_In is a valid sample this cycle.
- Data_Out  output  1  recovered direction bit (1 = up, 0 = down).
- Data_Valid  output  1  one-cycle pulse; Data_Out is new this cycle.
- Step_Error  output  1  one-cycle pulse; illegal step detected.
- Locked  output  1  high while the decoder is in the TRACK state.
- Error_Count  output  ERR_CNT_WIDTH  total illegal steps, saturating.

## Operation
- Internal registers:
  - Prev[1:0]: last valid sample.
  - Consec_Err[3:0]: consecutive illegal steps.
  - State: ACQUIRE or TRACK.
- Step arithmetic: Delta = (Count_In - Prev) mod 4, computed as a 2-bit wrap-around subtraction.
  - Delta 01 → legal up.
  - Delta 11 → legal down.
  - Delta 00 or 10 → illegal.
- ACQUIRE, sample valid:
  - Prev <= Count_In.
  - Go to TRACK.
  - No Data_Valid, no Step_Error.
- TRACK, sample valid and legal:
  - Data_Out <= 1 for up, 0 for down; Data_Valid pulses.
  - Consec_Err <= 0.
  - Prev <= Count_In.
- TRACK, sample valid and illegal:
  - Step_Error pulses.
  - Error_Count increments; it saturates at all-ones and does not wrap.
  - Consec_Err increments.
  - Prev <= Count_In, so the decoder resynchronises to the new value.
  - Data_Out holds; Data_Valid stays 0.
  - If the incremented Consec_Err equals FAULT_LIMIT, go to ACQUIRE and reset Consec_Err to 0.
- Count_Valid low:
  - No state change; Prev and Data_Out hold.
  - Data_Valid = 0, Step_Error = 0.
- Clear (priority over Count_Valid in the same cycle):
  - State <= ACQUIRE.
  - Prev, Consec_Err, Error_Count, Data_Out, Data_Valid and Step_Error all go to 0.
  - The sample presented in that cycle is discarded.
- Wrap-around is legal in both directions: 11→00 is up, 00→11 is down.

## Timing
- Reset values:
  - Data_Out 0, Data_Valid 0, Step_Error 0, Locked 0, Error_Count 0.
  - State ACQUIRE, Prev 00, Consec_Err 0.
- All outputs are registered. Latency is one cycle: a sample accepted at edge N produces Data_Valid/Step_Error during cycle N+1.
- Data_Valid and Step_Error are never high in the same cycle. Each is high for exactly one cycle per accepted sample.
- Locked rises at the edge that accepts the first sample in ACQUIRE, so Data_Valid can first pulse one sample later.
- Locked falls at the edge that records the FAULT_LIMIT-th consecutive illegal step. The Step_Error pulse for that step is still emitted in the same cycle.
- Reset asserted mid-stream clears everything immediately, with no clock needed. After release, the first valid sample is treated as an acquisition sample.
- Count_Valid may be high every cycle; there is no back-pressure.

## Test plan
- Reset, then Count_In 00,01,10,11,10,01 with Count_Valid held high:
  - Locked = 1 after the first sample.
  - Data_Valid pulses 5 times with Data_Out 1,1,1,0,0.
  - Error_Count = 0.
- Wrap-around, samples 11,00,11:
  - Data_Out 1 then 0.
  - No Step_Error.
- Illegal steps, samples 00,01,01,11,00:
  - Step_Error on 01→01 (hold) and on 01→11 (skip).
  - Data_Valid with Data_Out = 1 on 11→00.
  - Error_Count = 2; Locked stays 1.
- Loss of lock (FAULT_LIMIT = 3), samples 00,00,00,00,01,10:
  - Three Step_Error pulses, then Locked = 0.
  - Sample 01 re-acquires with no Data_Valid.
  - Sample 10 gives Data_Out = 1.
- Error_Count saturation (ERR_CNT_WIDTH = 2):
  - Drive 6 isolated illegal steps, re-acquiring as needed.
  - Error_Count stops at 3.
- Gaps, Clear and Reset:
  - Count_Valid low between samples: outputs hold and pulses stay 0.
  - Clear asserted together with a valid sample: sample ignored, Locked = 0, Error_Count = 0.
  - Reset pulsed mid-stream: all outputs 0 asynchronously.

Source files
------------

// File: rtl/up_down_direction_decoder.sv
// Recovers the up/down direction bit from a stream of 2-bit counter samples,
// flagging and counting illegal steps and tracking lock to the sequence.
module up_down_direction_decoder #(
   parameter int unsigned ERR_CNT_WIDTH = 8,
   parameter int unsigned FAULT_LIMIT   = 3
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Clear,
   input  logic [1:0]               Count_In,
   input  logic                     Count_Valid,
   output logic                     Data_Out,
   output logic                     Data_Valid,
   output logic                     Step_Error,
   output logic                     Locked,
   output logic [ERR_CNT_WIDTH-1:0] Error_Count
);

   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } state_t;

   localparam logic [3:0] LIMIT = 4'(FAULT_LIMIT);

   state_t     state;
   logic [1:0] prev;
   logic [1:0] delta;
   logic [3:0] consec;
   logic [3:0] consec_inc;
   logic       legal;
   logic       ec_full;

   // Legal steps are +1 (01) or -1 (11) mod 4, i.e. odd deltas
   assign delta      = Count_In - prev;
   assign legal      = delta[0];
   assign consec_inc = consec + 4'd1;
   assign ec_full    = &Error_Count;
   assign Locked     = (state == TRACK);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state       <= ACQUIRE;
         prev        <= 2'b00;
         consec      <= 4'd0;
         Error_Count <= '0;
         Data_Out    <= 1'b0;
         Data_Valid  <= 1'b0;
         Step_Error  <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         Step_Error <= 1'b0;
         if (Clear) begin
            state       <= ACQUIRE;
            prev        <= 2'b00;
            consec      <= 4'd0;
            Error_Count <= '0;
            Data_Out    <= 1'b0;
         end else if (Count_Valid) begin
            prev <= Count_In;
            case (state)
               ACQUIRE: begin
                  state <= TRACK;
               end
               TRACK: begin
                  if (legal) begin
                     Data_Out   <= ~delta[1];
                     Data_Valid <= 1'b1;
                     consec     <= 4'd0;
                  end else begin
                     Step_Error <= 1'b1;
                     if (!ec_full)
                        Error_Count <= Error_Count + 1'b1;
                     if (consec_inc == LIMIT) begin
                        state  <= ACQUIRE;
                        consec <= 4'd0;
                     end else begin
                        consec <= consec_inc;
                     end
                  end
               end
               default: state <= ACQUIRE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_up_down_direction_decoder.sv
// Self-checking bench: directed vector table, hand sequences and randomized
// stimulus compared against a behavioural model of the direction decoder.
module tb_up_down_direction_decoder;

   logic       Clock;
   logic       Reset;
   logic       Clear;
   logic [1:0] Count_In;
   logic       Count_Valid;

   logic       do_a, dv_a, se_a, lk_a;
   logic [7:0] ec_a;
   logic       do_b, dv_b, se_b, lk_b;
   logic [1:0] ec_b;

   int checks = 0;
   int failures = 0;

   up_down_direction_decoder #(.ERR_CNT_WIDTH(8), .FAULT_LIMIT(3)) dut (
      .Clock(Clock), .Reset(Reset), .Clear(Clear),
      .Count_In(Count_In), .Count_Valid(Count_Valid),
      .Data_Out(do_a), .Data_Valid(dv_a), .Step_Error(se_a),
      .Locked(lk_a), .Error_Count(ec_a)
   );

   up_down_direction_decoder #(.ERR_CNT_WIDTH(2), .FAULT_LIMIT(3)) dut2 (
      .Clock(Clock), .Reset(Reset), .Clear(Clear),
      .Count_In(Count_In), .Count_Valid(Count_Valid),
      .Data_Out(do_b), .Data_Valid(dv_b), .Step_Error(se_b),
      .Locked(lk_b), .Error_Count(ec_b)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // behavioural model state
   int m_prev, m_consec, m_ec;
   bit m_lk, m_do, m_dv, m_se;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_prev = 0; m_consec = 0; m_ec = 0;
      m_lk = 0; m_do = 0; m_dv = 0; m_se = 0;
   endtask

   task automatic model_step(input bit clr, input bit vld, input int cin);
      int d;
      m_dv = 0;
      m_se = 0;
      if (clr) begin
         model_reset();
      end else if (vld) begin
         if (!m_lk) begin
            m_lk = 1;
         end else begin
            d = (cin + 4 - m_prev) % 4;
            if (d == 1 || d == 3) begin
               m_dv = 1;
               m_do = (d == 1);
               m_consec = 0;
            end else begin
               m_se = 1;
               m_ec++;
               m_consec++;
               if (m_consec == 3) begin
                  m_lk = 0;
                  m_consec = 0;
               end
            end
         end
         m_prev = cin;
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, ".dv"}, dv_a, m_dv);
      chk({tag, ".do"}, do_a, m_do);
      chk({tag, ".se"}, se_a, m_se);
      chk({tag, ".lk"}, lk_a, m_lk);
      chk({tag, ".ec"}, ec_a, sat(m_ec, 255));
      chk({tag, ".dv2"}, dv_b, m_dv);
      chk({tag, ".se2"}, se_b, m_se);
      chk({tag, ".lk2"}, lk_b, m_lk);
      chk({tag, ".ec2"}, ec_b, sat(m_ec, 3));
   endtask

   task automatic drive(input bit clr, input bit vld, input int cin,
                        input string tag);
      @(negedge Clock);
      Clear = clr;
      Count_Valid = vld;
      Count_In = 2'(cin);
      @(posedge Clock);
      #1;
      model_step(clr, vld, cin);
      cmp_model(tag);
   endtask

   typedef struct {
      bit clr, vld;
      int cin;
      bit dv, dout, se, lk;
      int ec;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input bit clr, input bit vld, input int cin,
                              input bit dv, input bit dout, input bit se,
                              input bit lk, input int ec);
      vec_t r;
      r.clr = clr; r.vld = vld; r.cin = cin;
      r.dv = dv; r.dout = dout; r.se = se; r.lk = lk; r.ec = ec;
      return r;
   endfunction

   initial begin
      Reset = 1'b0;
      Clear = 1'b0;
      Count_Valid = 1'b0;
      Count_In = 2'b00;
      model_reset();

      // counting up then down
      tbl.push_back(v(0,1,0, 0,0,0,1,0));
      tbl.push_back(v(0,1,1, 1,1,0,1,0));
      tbl.push_back(v(0,1,2, 1,1,0,1,0));
      tbl.push_back(v(0,1,3, 1,1,0,1,0));
      tbl.push_back(v(0,1,2, 1,0,0,1,0));
      tbl.push_back(v(0,1,1, 1,0,0,1,0));
      // wrap-around
      tbl.push_back(v(1,1,3, 0,0,0,0,0));
      tbl.push_back(v(0,1,3, 0,0,0,1,0));
      tbl.push_back(v(0,1,0, 1,1,0,1,0));
      tbl.push_back(v(0,1,3, 1,0,0,1,0));
      // hold and skip
      tbl.push_back(v(1,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,1,0, 0,0,0,1,0));
      tbl.push_back(v(0,1,1, 1,1,0,1,0));
      tbl.push_back(v(0,1,1, 0,1,1,1,1));
      tbl.push_back(v(0,1,3, 0,1,1,1,2));
      tbl.push_back(v(0,1,0, 1,1,0,1,2));
      // loss of lock and re-acquire
      tbl.push_back(v(1,0,0, 0,0,0,0,0));
      tbl.push_back(v(0,1,0, 0,0,0,1,0));
      tbl.push_back(v(0,1,0, 0,0,1,1,1));
      tbl.push_back(v(0,1,0, 0,0,1,1,2));
      tbl.push_back(v(0,1,0, 0,0,1,0,3));
      tbl.push_back(v(0,1,1, 0,0,0,1,3));
      tbl.push_back(v(0,1,2, 1,1,0,1,3));
      // gaps hold outputs
      tbl.push_back(v(0,0,3, 0,1,0,1,3));
      tbl.push_back(v(0,0,0, 0,1,0,1,3));
      tbl.push_back(v(0,1,3, 1,1,0,1,3));
      // clear with a valid sample discards it
      tbl.push_back(v(1,1,0, 0,0,0,0,0));
      tbl.push_back(v(0,1,2, 0,0,0,1,0));
      tbl.push_back(v(0,1,1, 1,0,0,1,0));

      #2;
      chk("rst.do", do_a, 0);
      chk("rst.dv", dv_a, 0);
      chk("rst.se", se_a, 0);
      chk("rst.lk", lk_a, 0);
      chk("rst.ec", ec_a, 0);
      @(negedge Clock);
      Reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].clr, tbl[i].vld, tbl[i].cin, $sformatf("vec%0d", i));
         chk($sformatf("tbl%0d.dv", i), dv_a, tbl[i].dv);
         chk($sformatf("tbl%0d.do", i), do_a, tbl[i].dout);
         chk($sformatf("tbl%0d.se", i), se_a, tbl[i].se);
         chk($sformatf("tbl%0d.lk", i), lk_a, tbl[i].lk);
         chk($sformatf("tbl%0d.ec", i), ec_a, tbl[i].ec);
         chk($sformatf("tbl%0d.ec2", i), ec_b, tbl[i].ec);
      end

      // saturation: six isolated illegal steps
      drive(1, 0, 0, "sat.clr");
      drive(0, 1, 0, "sat.acq");
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, k % 4, "sat.hold");
         drive(0, 1, (k + 1) % 4, "sat.up");
      end
      chk("sat.ec8", ec_a, 6);
      chk("sat.ec2", ec_b, 3);
      chk("sat.lk", lk_a, 1);

      // asynchronous reset mid-stream
      drive(0, 1, 3, "ar.pre");
      @(negedge Clock);
      Count_Valid = 1'b0;
      Reset = 1'b0;
      #1;
      chk("ar.do", do_a, 0);
      chk("ar.dv", dv_a, 0);
      chk("ar.se", se_a, 0);
      chk("ar.lk", lk_a, 0);
      chk("ar.ec", ec_a, 0);
      model_reset();
      @(negedge Clock);
      Reset = 1'b1;
      drive(0, 1, 2, "ar.acq");
      chk("ar.acq_dv", dv_a, 0);
      drive(0, 1, 1, "ar.down");

      // randomized stream
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 3)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
